impulse_seq: RTL and testbench

IMPULSE_SEQ -- requirements
Module: impulse_seq

---
 rtl/impulse_seq_if.sv | 25 ++
 rtl/impulse_seq.sv | 181 ++++++++++++++++++
 tb/tb_impulse_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/impulse_seq_if.sv
// Command bus between the command-memory writer and impulse_seq.
// The writer strobes DATA_WR with all fields valid; the sequencer answers with REQ_COMM.
interface impulse_seq_if;
  logic        DATA_WR;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;
  logic [31:0] Interval_Ti;
  logic [31:0] Interval_Tp;
  logic [31:0] Tblank1;
  logic [31:0] Tblank2;
  logic        REQ_COMM;

  modport master (
    output DATA_WR, TIME_START, N_impulse, TYPE_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    input  REQ_COMM
  );

  modport slave (
    input  DATA_WR, TIME_START, N_impulse, TYPE_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    output REQ_COMM
  );
endinterface

// File: rtl/impulse_seq.sv
// Time-triggered impulse sequencer: waits for a start time, then plays
// BLANK1 / N x (PULSE, GAP) / BLANK2 and requests the next command.
module impulse_seq #(
  parameter int unsigned REQ_LEN = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [63:0]       TIME,
  impulse_seq_if.slave      cmd,
  output logic              IMP,
  output logic              BLANK,
  output logic              BUSY,
  output logic [1:0]        TYPE_z,
  output logic [15:0]       IMP_CNT,
  output logic              ERR_LATE,
  output logic              ERR_BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    BLANK1,
    PULSE,
    GAP,
    BLANK2,
    REQ
  } state_t;

  // A step is the state to enter, its length in cycles and the impulse count on entry.
  typedef struct packed {
    state_t      st;
    logic [31:0] len;
    logic [15:0] cnt;
  } step_t;

  localparam logic [31:0] REQ_CYC = (REQ_LEN == 0) ? 32'd1 : 32'(REQ_LEN);

  state_t      state;
  logic [31:0] cnt;
  logic [63:0] start_t;
  logic [15:0] n_lat;
  logic [31:0] ti_lat;
  logic [31:0] tp_lat;
  logic [31:0] tb1_lat;
  logic [31:0] tb2_lat;

  logic [31:0] gap_len;
  logic        timer_done;
  logic        running;
  logic        do_latch;
  logic        late;

  step_t req_step;
  step_t blank2_step;
  step_t pulse_step;
  step_t decide_step;
  step_t start_step;
  step_t after_pulse_step;
  step_t nx;

  function automatic step_t mk_step(state_t s, logic [31:0] l, logic [15:0] c);
    step_t r;
    r.st  = s;
    r.len = l;
    r.cnt = c;
    return r;
  endfunction

  assign gap_len    = (tp_lat > ti_lat) ? (tp_lat - ti_lat) : '0;
  assign timer_done = (cnt <= 32'd1);
  assign running    = (state != IDLE) && (state != ARMED);

  // Resolve zero-length states so a skipped state never costs a cycle.
  // With Ti and the gap both zero, every remaining impulse collapses at once.
  always_comb begin
    req_step = mk_step(REQ, REQ_CYC, IMP_CNT);

    if (tb2_lat != '0) blank2_step = mk_step(BLANK2, tb2_lat, IMP_CNT);
    else               blank2_step = req_step;

    if (ti_lat != '0) begin
      pulse_step = mk_step(PULSE, ti_lat, IMP_CNT + 16'd1);
    end else if (gap_len != '0) begin
      pulse_step = mk_step(GAP, gap_len, IMP_CNT + 16'd1);
    end else begin
      pulse_step     = blank2_step;
      pulse_step.cnt = n_lat;
    end

    if (IMP_CNT < n_lat) decide_step = pulse_step;
    else                 decide_step = blank2_step;

    if (tb1_lat != '0) start_step = mk_step(BLANK1, tb1_lat, IMP_CNT);
    else               start_step = decide_step;

    if (gap_len != '0) after_pulse_step = mk_step(GAP, gap_len, IMP_CNT);
    else               after_pulse_step = decide_step;
  end

  always_comb begin
    nx       = mk_step(state, cnt, IMP_CNT);
    do_latch = 1'b0;
    late     = 1'b0;
    case (state)
      IDLE, ARMED: begin
        if (cmd.DATA_WR) begin
          do_latch = 1'b1;
          if (cmd.TIME_START <= TIME) begin
            late = 1'b1;
            nx   = mk_step(REQ, REQ_CYC, 16'd0);
          end else begin
            nx   = mk_step(ARMED, 32'd0, 16'd0);
          end
        end else if ((state == ARMED) && (TIME >= start_t)) begin
          nx = start_step;
        end
      end
      BLANK1, GAP: begin
        if (timer_done) nx = decide_step;
        else            nx = mk_step(state, cnt - 32'd1, IMP_CNT);
      end
      PULSE: begin
        if (timer_done) nx = after_pulse_step;
        else            nx = mk_step(PULSE, cnt - 32'd1, IMP_CNT);
      end
      BLANK2: begin
        if (timer_done) nx = req_step;
        else            nx = mk_step(BLANK2, cnt - 32'd1, IMP_CNT);
      end
      REQ: begin
        if (timer_done) nx = mk_step(IDLE, 32'd0, IMP_CNT);
        else            nx = mk_step(REQ, cnt - 32'd1, IMP_CNT);
      end
      default: nx = mk_step(IDLE, 32'd0, IMP_CNT);
    endcase
  end

  // Outputs are decoded from the next state so each gate is high in the first cycle of its state.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      IMP          <= 1'b0;
      BLANK        <= 1'b0;
      BUSY         <= 1'b0;
      cmd.REQ_COMM <= 1'b0;
      IMP_CNT      <= '0;
      TYPE_z       <= '0;
      ERR_LATE     <= 1'b0;
      ERR_BUSY     <= 1'b0;
      start_t      <= '0;
      n_lat        <= '0;
      ti_lat       <= '0;
      tp_lat       <= '0;
      tb1_lat      <= '0;
      tb2_lat      <= '0;
    end else begin
      state        <= nx.st;
      cnt          <= nx.len;
      IMP_CNT      <= nx.cnt;
      IMP          <= (nx.st == PULSE);
      BLANK        <= (nx.st == BLANK1) || (nx.st == BLANK2);
      BUSY         <= (nx.st != IDLE);
      cmd.REQ_COMM <= (nx.st == REQ);
      ERR_LATE     <= late;
      if (cmd.DATA_WR && running) begin
        ERR_BUSY <= 1'b1;
      end
      if (do_latch) begin
        start_t <= cmd.TIME_START;
        n_lat   <= cmd.N_impulse;
        ti_lat  <= cmd.Interval_Ti;
        tp_lat  <= cmd.Interval_Tp;
        tb1_lat <= cmd.Tblank1;
        tb2_lat <= cmd.Tblank2;
        TYPE_z  <= cmd.TYPE_impulse;
      end
    end
  end

endmodule

// File: tb/tb_impulse_seq.sv
// Bench for impulse_seq: each command is expanded into its expected per-cycle
// waveform on a scoreboard queue, which is popped once per clock.
module tb_impulse_seq;
  localparam int REQ_LEN = 4;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [63:0] sys_time;
  logic        IMP, BLANK, BUSY, ERR_LATE, ERR_BUSY;
  logic [1:0]  TYPE_z;
  logic [15:0] IMP_CNT;

  impulse_seq_if bus();

  impulse_seq #(.REQ_LEN(REQ_LEN)) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .TIME     (sys_time),
    .cmd      (bus),
    .IMP      (IMP),
    .BLANK    (BLANK),
    .BUSY     (BUSY),
    .TYPE_z   (TYPE_z),
    .IMP_CNT  (IMP_CNT),
    .ERR_LATE (ERR_LATE),
    .ERR_BUSY (ERR_BUSY)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic        imp;
    logic        blank;
    logic        busy;
    logic        req;
    logic        late;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [63:0] t0;
    logic [63:0] start;
    int          n;
    int          ty;
    int          ti;
    int          tp;
    int          tb1;
    int          tb2;
    bit          late;
    int          cnt;
  } vec_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[8];
  vec_t hv;
  vec_t hv2;

  function automatic exp_t mk(int imp, int blank, int busy, int req, int late, int cnt);
    exp_t e;
    e.imp   = imp[0];
    e.blank = blank[0];
    e.busy  = busy[0];
    e.req   = req[0];
    e.late  = late[0];
    e.cnt   = cnt[15:0];
    return e;
  endfunction

  task automatic pushN(int n, exp_t e);
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Expected waveform as a list of segments: armed wait, blank, N x (pulse, gap), blank, request.
  task automatic pushExpected(vec_t v);
    if (v.late) begin
      pushN(1, mk(0, 0, 1, 1, 1, 0));
      pushN(REQ_LEN - 1, mk(0, 0, 1, 1, 0, 0));
      pushN(2, mk(0, 0, 0, 0, 0, 0));
    end else begin
      pushN(int'(v.start - v.t0), mk(0, 0, 1, 0, 0, 0));
      pushN(v.tb1, mk(0, 1, 1, 0, 0, 0));
      for (int k = 1; k <= v.n; k++) begin
        pushN(v.ti, mk(1, 0, 1, 0, 0, k));
        pushN((v.tp > v.ti) ? (v.tp - v.ti) : 0, mk(0, 0, 1, 0, 0, k));
      end
      pushN(v.tb2, mk(0, 1, 1, 0, 0, v.cnt));
      pushN(REQ_LEN, mk(0, 0, 1, 1, 0, v.cnt));
      pushN(2, mk(0, 0, 0, 0, 0, v.cnt));
    end
  endtask

  task automatic setCmd(vec_t v);
    bus.TIME_START   = v.start;
    bus.N_impulse    = v.n[15:0];
    bus.TYPE_impulse = v.ty[1:0];
    bus.Interval_Ti  = v.ti;
    bus.Interval_Tp  = v.tp;
    bus.Tblank1      = v.tb1;
    bus.Tblank2      = v.tb2;
    bus.DATA_WR      = 1'b1;
  endtask

  task automatic checkOutput();
    exp_t got;
    exp_t e;
    got = '{IMP, BLANK, BUSY, bus.REQ_COMM, ERR_LATE, IMP_CNT};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty time=%0d got=%h", sys_time, got);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL outputs time=%0d got imp,blank,busy,req,late=%b%b%b%b%b cnt=%0d required %b%b%b%b%b cnt=%0d",
                 sys_time, got.imp, got.blank, got.busy, got.req, got.late, got.cnt,
                 e.imp, e.blank, e.busy, e.req, e.late, e.cnt);
      end
    end
  endtask

  task automatic checkValue(string name, logic [15:0] got, logic [15:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    bus.DATA_WR = 1'b0;
    checkOutput();
    sys_time = sys_time + 64'd1;
  endtask

  task automatic runCycles(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20000) begin
      tick();
      guard++;
    end
  endtask

  task automatic applyStimulus(vec_t v);
    sys_time = v.t0;
    setCmd(v);
    pushExpected(v);
    drain();
    checkValue("type_z", 16'(TYPE_z), 16'(v.ty[1:0]));
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //              t0        start     n  ty ti  tp  tb1 tb2 late cnt
    tbl[0] = '{64'd1000, 64'd1100, 3, 2, 5, 20, 10, 8, 1'b0, 3};
    tbl[1] = '{64'd2000, 64'd1500, 7, 1, 3,  9,  2, 2, 1'b1, 0};
    tbl[2] = '{64'd3000, 64'd3000, 1, 3, 1,  1,  1, 1, 1'b1, 0};
    tbl[3] = '{64'd4000, 64'd4003, 2, 0, 6,  4,  0, 0, 1'b0, 2};
    tbl[4] = '{64'd5000, 64'd5004, 0, 1, 4,  9,  3, 2, 1'b0, 0};
    tbl[5] = '{64'd6000, 64'd6002, 2, 2, 0,  3,  0, 1, 1'b0, 2};
    tbl[6] = '{64'd7000, 64'd7001, 3, 3, 0,  0,  0, 0, 1'b0, 3};
    tbl[7] = '{64'd8000, 64'd8001, 1, 1, 1,  2,  2, 0, 1'b0, 1};

    rst_n            = 1'b0;
    sys_time         = '0;
    bus.DATA_WR      = 1'b0;
    bus.TIME_START   = '0;
    bus.N_impulse    = '0;
    bus.TYPE_impulse = '0;
    bus.Interval_Ti  = '0;
    bus.Interval_Tp  = '0;
    bus.Tblank1      = '0;
    bus.Tblank2      = '0;

    pushN(3, mk(0, 0, 0, 0, 0, 0));
    runCycles(3);
    checkValue("reset_type_z", 16'(TYPE_z), 16'd0);
    checkValue("reset_err_busy", 16'(ERR_BUSY), 16'd0);

    // First command lands in the very first cycle after reset release.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);
    checkValue("err_busy_after_table", 16'(ERR_BUSY), 16'd0);

    // A newer command while armed replaces the pending one.
    hv = '{64'd2400, 64'd5000, 1, 1, 1, 2, 2, 0, 1'b0, 1};
    sys_time = hv.t0;
    setCmd(hv);
    pushN(100, mk(0, 0, 1, 0, 0, 0));
    runCycles(100);
    hv2 = '{64'd2500, 64'd3000, 1, 2, 1, 2, 2, 0, 1'b0, 1};
    setCmd(hv2);
    pushExpected(hv2);
    drain();
    checkValue("rearm_type_z", 16'(TYPE_z), 16'd2);
    checkValue("rearm_err_busy", 16'(ERR_BUSY), 16'd0);
    sys_time = 64'd4998;
    pushN(6, mk(0, 0, 0, 0, 0, 1));
    runCycles(6);

    // A command arriving mid-pulse is dropped and flags ERR_BUSY.
    hv = '{64'd9000, 64'd9002, 2, 3, 4, 6, 1, 1, 1'b0, 2};
    sys_time = hv.t0;
    setCmd(hv);
    pushExpected(hv);
    runCycles(4);
    hv2 = '{64'd9004, 64'd9100, 5, 1, 1, 1, 1, 1, 1'b0, 5};
    setCmd(hv2);
    drain();
    checkValue("err_busy_sticky", 16'(ERR_BUSY), 16'd1);
    checkValue("busy_type_hold", 16'(TYPE_z), 16'd3);

    // Reset for one cycle in the gap after the second impulse.
    hv = '{64'd10000, 64'd10001, 3, 2, 2, 5, 0, 0, 1'b0, 3};
    sys_time = hv.t0;
    setCmd(hv);
    pushExpected(hv);
    runCycles(9);
    rst_n = 1'b0;
    sb.delete();
    pushN(1, mk(0, 0, 0, 0, 0, 0));
    tick();
    checkValue("midreset_type_z", 16'(TYPE_z), 16'd0);
    checkValue("midreset_err_busy", 16'(ERR_BUSY), 16'd0);
    rst_n = 1'b1;
    pushN(8, mk(0, 0, 0, 0, 0, 0));
    runCycles(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
